// File: rtl/vdp_pkg.sv
// Shared types and slot map for the VDP VRAM arbiter.
package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } cpu_state_e;

  localparam logic [2:0] SLOT_NAME = 3'd0;
  localparam logic [2:0] SLOT_PAT  = 3'd4;

  // Decision -> address on VRAM -> read data back: two cycles.
  localparam int unsigned DISP_LAT = 2;
  localparam logic [2:0] SLOT_NAME_VLD = SLOT_NAME + 3'(DISP_LAT);
  localparam logic [2:0] SLOT_PAT_VLD  = SLOT_PAT + 3'(DISP_LAT);

endpackage

// File: rtl/vdp_vram_arb.sv
// Time-slot VRAM arbiter: display owns slots 0/4 of each 8-pixel cell in the active window, CPU takes the rest.
// CPU ack arrives 3 cycles after req (4 if the request lands on a display slot); one transaction per 4 cycles.
module vdp_vram_arb
  import vdp_pkg::*;
#(
  parameter int AW      = 14,
  parameter int DW      = 8,
  parameter int HVID    = 640,
  parameter int VVID    = 480,
  parameter int HC_BITS = 10,
  parameter int VC_BITS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [HC_BITS-1:0] col,
  input  logic [VC_BITS-1:0] row,
  input  logic               disp_en,
  input  logic [AW-1:0]      disp_name_addr,
  input  logic [AW-1:0]      disp_pat_addr,
  output logic               disp_name_vld,
  output logic               disp_pat_vld,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic               cpu_ack,
  output logic [DW-1:0]      cpu_rdata,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  cpu_state_e    state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          op_we_q, op_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          name_tag_q, pat_tag_q;
  logic          name_vld_q, pat_vld_q;

  logic [2:0] slot;
  logic       disp_win;
  logic       name_slot;
  logic       pat_slot;

  assign slot      = col[2:0];
  assign disp_win  = disp_en && (row < VC_BITS'(VVID)) && (col < HC_BITS'(HVID));
  assign name_slot = disp_win && (slot == SLOT_NAME);
  assign pat_slot  = disp_win && (slot == SLOT_PAT);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    op_we_d     = op_we_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;

    // Display may retarget the bus while a CPU access is in WAIT/ISSUE: the
    // CPU address has already been seen by the VRAM by then.
    if (name_slot) begin
      mem_addr_d = disp_name_addr;
    end else if (pat_slot) begin
      mem_addr_d = disp_pat_addr;
    end

    unique case (state_q)
      IDLE: begin
        if (cpu_req && !(name_slot || pat_slot)) begin
          mem_addr_d  = cpu_addr;
          mem_we_d    = cpu_we;
          mem_wdata_d = cpu_wdata;
          op_we_d     = cpu_we;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!op_we_q) begin
          cpu_rdata_d = mem_rdata;
        end
        cpu_ack_d = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      op_we_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      name_tag_q  <= 1'b0;
      pat_tag_q   <= 1'b0;
      name_vld_q  <= 1'b0;
      pat_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      op_we_q     <= op_we_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      name_tag_q  <= name_slot;
      pat_tag_q   <= pat_slot;
      name_vld_q  <= name_tag_q;
      pat_vld_q   <= pat_tag_q;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign disp_name_vld = name_vld_q;
  assign disp_pat_vld  = pat_vld_q;

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Directed bench for vdp_vram_arb: vector table of CPU transactions plus multi-cycle sequences.
module tb_vdp_vram_arb;

  localparam logic [13:0] NAME_A = 14'h0300;
  localparam logic [13:0] PAT_A  = 14'h0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  col, row;
  logic        disp_en;
  logic [13:0] disp_name_addr, disp_pat_addr;
  logic        disp_name_vld, disp_pat_vld;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  int clash  = 0;
  int cyc    = 0;

  logic [7:0] ram [0:16383];

  vdp_vram_arb dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .disp_en(disp_en),
    .disp_name_addr(disp_name_addr), .disp_pat_addr(disp_pat_addr),
    .disp_name_vld(disp_name_vld), .disp_pat_vld(disp_pat_vld),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port VRAM, read data one cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  function automatic logic [7:0] pat(input logic [13:0] a);
    pat = a[7:0] ^ {a[13:8], a[1:0]} ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One pixel clock; sync-generator position advances like the real counter.
  task automatic tick();
    logic resv;
    resv = disp_en && (row < 10'd480) && (col < 10'd640) &&
           ((col[2:0] == 3'd0) || (col[2:0] == 3'd4));
    @(posedge clk);
    #1;
    if (resv && mem_we) clash++;
    if (col == 10'd799) begin
      col = 10'd0;
      row = (row == 10'd524) ? 10'd0 : row + 10'd1;
    end else begin
      col = col + 10'd1;
    end
  endtask

  task automatic cpu_txn(input logic [9:0] c, input logic [9:0] r, input logic den,
                         input logic we, input logic [13:0] a, input logic [7:0] wd,
                         output int lat, output logic [13:0] a1, output logic [7:0] rd);
    col = c; row = r; disp_en = den;
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    tick();
    a1  = mem_addr;
    lat = 1;
    while (!cpu_ack && lat < 10) begin
      tick();
      lat++;
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [9:0]  c;
    logic [9:0]  r;
    logic        den;
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wd;
    int          exp_lat;
    logic [13:0] exp_a1;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vt [11];

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, acks, last_ack, gap, ncnt, pcnt, bad, off;
    logic [13:0] a1;
    logic [7:0]  rd;

    reset = 1'b0;
    col = '0; row = '0; disp_en = 1'b0;
    disp_name_addr = NAME_A; disp_pat_addr = PAT_A;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 16384; i++) ram[i] = pat(i[13:0]);

    #5;
    chk("reset_outputs",
        {disp_name_vld, disp_pat_vld, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();

    //            col     row   den  we    addr      wd     lat  a1        rd
    vt[0]  = '{10'd3,   10'd500, 1'b1, 1'b0, 14'h1234, 8'h00, 3, 14'h1234, pat(14'h1234)};
    vt[1]  = '{10'd16,  10'd10,  1'b1, 1'b0, 14'h0055, 8'h00, 4, NAME_A,   pat(14'h0055)};
    vt[2]  = '{10'd20,  10'd10,  1'b1, 1'b0, 14'h0066, 8'h00, 4, PAT_A,    pat(14'h0066)};
    vt[3]  = '{10'd17,  10'd10,  1'b1, 1'b1, 14'h0200, 8'hA5, 3, 14'h0200, pat(14'h0066)};
    vt[4]  = '{10'd21,  10'd10,  1'b1, 1'b0, 14'h0200, 8'h00, 3, 14'h0200, 8'hA5};
    vt[5]  = '{10'd16,  10'd10,  1'b0, 1'b0, 14'h0077, 8'h00, 3, 14'h0077, pat(14'h0077)};
    vt[6]  = '{10'd640, 10'd10,  1'b1, 1'b0, 14'h0088, 8'h00, 3, 14'h0088, pat(14'h0088)};
    vt[7]  = '{10'd632, 10'd479, 1'b1, 1'b0, 14'h0099, 8'h00, 4, NAME_A,   pat(14'h0099)};
    vt[8]  = '{10'd8,   10'd480, 1'b1, 1'b0, 14'h0AAA, 8'h00, 3, 14'h0AAA, pat(14'h0AAA)};
    vt[9]  = '{10'd799, 10'd524, 1'b1, 1'b0, 14'h3FFF, 8'h00, 3, 14'h3FFF, pat(14'h3FFF)};
    vt[10] = '{10'd4,   10'd0,   1'b1, 1'b1, 14'h3FFF, 8'h00, 4, PAT_A,    pat(14'h3FFF)};

    for (int i = 0; i < 11; i++) begin
      cpu_txn(vt[i].c, vt[i].r, vt[i].den, vt[i].we, vt[i].addr, vt[i].wd, lat, a1, rd);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_first_addr", i), a1, vt[i].exp_a1);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end
    chk("vec10_ram", ram[14'h3FFF], 8'h00);

    // Contention on slot 0: name fetch first, CPU one slot later.
    col = 10'd16; row = 10'd10; disp_en = 1'b1;
    cpu_we = 1'b0; cpu_addr = 14'h0123; cpu_req = 1'b1;
    tick();
    chk("cont_name_addr", mem_addr, NAME_A);
    tick();
    chk("cont_name_vld", disp_name_vld, 1'b1);
    chk("cont_name_data", mem_rdata, pat(NAME_A));
    chk("cont_cpu_addr", mem_addr, 14'h0123);
    tick();
    chk("cont_no_ack_early", cpu_ack, 1'b0);
    tick();
    chk("cont_ack_col20", {col, cpu_ack}, {10'd20, 1'b1});
    chk("cont_rdata", cpu_rdata, pat(14'h0123));
    cpu_req = 1'b0;
    tick();

    // Tags follow the access even when the window closes behind it.
    col = 10'd632; row = 10'd10; disp_en = 1'b1;
    tick();
    disp_en = 1'b0;
    tick();
    chk("tag_name_after_win", disp_name_vld, 1'b1);
    repeat (4) tick();
    chk("tag_no_pat_when_off", disp_pat_vld, 1'b0);

    // Back-to-back writes with the request held high through active video.
    col = 10'd0; row = 10'd10; disp_en = 1'b1;
    cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'hC0; cpu_req = 1'b1;
    acks = 0; last_ack = 0;
    for (int t = 0; t < 200 && acks < 8; t++) begin
      tick();
      if (cpu_ack) begin
        if (acks > 0) begin
          gap = cyc - last_ack;
          chk($sformatf("b2b_gap%0d_in_4_5", acks), (gap >= 4) && (gap <= 5), 1'b1);
        end
        last_ack = cyc;
        acks++;
        cpu_addr  = cpu_addr + 14'd1;
        cpu_wdata = cpu_wdata + 8'd1;
        if (acks == 8) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    tick();
    chk("b2b_ack_count", acks, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b2b_ram%0d", i), ram[14'h0100 + 14'(i)], 8'hC0 + 8'(i));
    chk("disp_slot_we_clash", clash, 0);

    // Full display line: one name and one pattern fetch per cell.
    disp_en = 1'b0;
    repeat (3) tick();
    col = 10'd0; row = 10'd0; disp_en = 1'b1;
    ncnt = 0; pcnt = 0; bad = 0; off = 0;
    for (int t = 0; t < 800; t++) begin
      disp_name_addr = 14'h0800 + 14'(col >> 3);
      disp_pat_addr  = 14'h1000 + 14'(col >> 3);
      tick();
      if (disp_name_vld) begin
        ncnt++;
        if (col[2:0] != 3'd2 || mem_rdata != pat(14'h0800 + 14'(col >> 3))) bad++;
      end
      if (disp_pat_vld) begin
        pcnt++;
        if (col[2:0] != 3'd6 || mem_rdata != pat(14'h1000 + 14'(col >> 3))) bad++;
      end
    end
    chk("line_name_strobes", ncnt, 80);
    chk("line_pat_strobes", pcnt, 80);
    chk("line_strobe_slot_data", bad, 0);
    col = 10'd0; row = 10'd0; disp_en = 1'b0;
    for (int t = 0; t < 800; t++) begin
      tick();
      if (disp_name_vld || disp_pat_vld) off++;
    end
    chk("line_disabled_strobes", off, 0);
    disp_name_addr = NAME_A; disp_pat_addr = PAT_A;

    // Reset lands while a write is on the bus.
    row = 10'd500; col = 10'd3; disp_en = 1'b1;
    cpu_we = 1'b1; cpu_addr = 14'h0222; cpu_wdata = 8'h77; cpu_req = 1'b1;
    tick();
    chk("rst_issue_we", mem_we, 1'b1);
    #5 reset = 1'b0;
    #1;
    chk("rst_async_outputs",
        {disp_name_vld, disp_pat_vld, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata}, 32'd0);
    acks = 0;
    repeat (3) begin
      tick();
      if (cpu_ack || mem_we) acks++;
    end
    chk("rst_no_ack_no_we", acks, 0);
    chk("rst_no_write", ram[14'h0222], pat(14'h0222));
    row = 10'd500;
    @(negedge clk) reset = 1'b1;
    lat = 0;
    while (!cpu_ack && lat < 10) begin
      tick();
      lat++;
    end
    chk("rst_reissue_latency", lat, 3);
    cpu_req = 1'b0;
    tick();
    chk("rst_reissue_write", ram[14'h0222], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
